// File: rtl/sysid_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysid_checker: reads sysid ID/timestamp words over Avalon-MM and compares. |
// | Optional read timeout: SYSID_CHECKER_TIMEOUT_EN.  Rev 1.0                  |
// +----------------------------------------------------------------------------+
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h11111111,
   parameter logic [31:0] EXPECTED_TS    = 32'h52F0E116,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RD_ID  = 2'd1,
      S_RD_TS  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_id_ok, w_id_ok_nxt;
   logic        r_ts_ok, w_ts_ok_nxt;
   logic [31:0] r_id_value, w_id_value_nxt;
   logic [31:0] r_ts_value, w_ts_value_nxt;
   logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
   logic        w_tmo_hit;
   logic        w_in_read;
   logic        w_accept;

   assign w_in_read = (r_state == S_RD_ID) || (r_state == S_RD_TS);
   assign w_accept  = (r_state == S_IDLE) && start;

`ifdef SYSID_CHECKER_TIMEOUT_EN
   logic r_timeout;

   assign w_tmo_hit = avm_waitrequest && (r_wait_cnt == C_TIMEOUT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_timeout <= 1'b0;
      end else if (w_accept) begin
         r_timeout <= 1'b0;
      end else if (w_in_read && w_tmo_hit) begin
         r_timeout <= 1'b1;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_tmo_hit = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_id_value <= 32'd0;
         r_ts_value <= 32'd0;
         r_wait_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_id_ok    <= w_id_ok_nxt;
         r_ts_ok    <= w_ts_ok_nxt;
         r_id_value <= w_id_value_nxt;
         r_ts_value <= w_ts_value_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_id_ok_nxt    = r_id_ok;
      w_ts_ok_nxt    = r_ts_ok;
      w_id_value_nxt = r_id_value;
      w_ts_value_nxt = r_ts_value;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt    = S_RD_ID;
               w_id_ok_nxt    = 1'b0;
               w_ts_ok_nxt    = 1'b0;
               w_wait_cnt_nxt = 16'd0;
            end
         end
         S_RD_ID: begin
            if (!avm_waitrequest) begin
               w_id_value_nxt = avm_readdata;
               w_id_ok_nxt    = (avm_readdata == EXPECTED_ID);
               w_wait_cnt_nxt = 16'd0;
               w_state_nxt    = S_RD_TS;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_FINISH;
            end else if (r_wait_cnt != C_TIMEOUT) begin
               w_wait_cnt_nxt = r_wait_cnt + 16'd1;
            end
         end
         S_RD_TS: begin
            if (!avm_waitrequest) begin
               w_ts_value_nxt = avm_readdata;
               w_ts_ok_nxt    = (avm_readdata == EXPECTED_TS);
               w_wait_cnt_nxt = 16'd0;
               w_state_nxt    = S_FINISH;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_FINISH;
            end else if (r_wait_cnt != C_TIMEOUT) begin
               w_wait_cnt_nxt = r_wait_cnt + 16'd1;
            end
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Bus strobes decode straight from state so reset drops them without a clock.
   assign avm_read    = w_in_read;
   assign avm_address = (r_state == S_RD_TS);
   assign busy        = w_in_read;
   assign done        = (r_state == S_FINISH);
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// Self-checking bench for sysid_checker: behavioural Avalon slave plus a
// sequence-level reference model of flags, captured words and latency.
module tb_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h11111111;
   localparam logic [31:0] EXP_TS = 32'h52F0E116;
   localparam int          TMO    = 8;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int errors = 0;
   int checks = 0;

   // slave configuration
   logic [31:0] s_data_id, s_data_ts;
   int          s_stall_id, s_stall_ts;
   int          s_cnt;
   logic [1:0]  s_key, s_prev_key;

   // reference model state
   logic [31:0] m_id_value, m_ts_value;
   bit          tmo_en;

   sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .busy           (busy),
      .done           (done),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .id_value       (id_value),
      .ts_value       (ts_value)
   );

   always #5 clock = ~clock;

   // Slave: stalls each read for a configured number of cycles, then completes.
   always @(negedge clock) begin
      s_key = avm_read ? {1'b1, avm_address} : 2'b00;
      if (avm_read && s_key == s_prev_key) s_cnt = s_cnt + 1;
      else s_cnt = 0;
      s_prev_key      = s_key;
      avm_waitrequest = avm_read && (s_cnt < (avm_address ? s_stall_ts : s_stall_id));
      avm_readdata    = avm_address ? s_data_ts : s_data_id;
   end

   task automatic run_seq(input logic [31:0] did, input logic [31:0] dts,
                          input int sid, input int sts, input string name);
      int  lat, c0, c1, n, e_lat, e_c0, e_c1;
      bit  order_err, id_to, ts_to, e_id_ok, e_ts_ok, e_tmo;
      s_data_id  = did;
      s_data_ts  = dts;
      s_stall_id = sid;
      s_stall_ts = sts;
      // reference model
      id_to = tmo_en && (sid > TMO);
      ts_to = tmo_en && !id_to && (sts > TMO);
      e_tmo = id_to || ts_to;
      if (id_to) begin
         e_c0 = TMO + 1; e_c1 = 0; e_id_ok = 0; e_ts_ok = 0;
      end else begin
         m_id_value = did;
         e_id_ok    = (did == EXP_ID);
         e_c0       = sid + 1;
         if (ts_to) begin
            e_c1 = TMO + 1; e_ts_ok = 0;
         end else begin
            m_ts_value = dts;
            e_ts_ok    = (dts == EXP_TS);
            e_c1       = sts + 1;
         end
      end
      e_lat = e_c0 + e_c1 + 1;

      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      lat = 0; c0 = 0; c1 = 0; n = 0; order_err = 0;
      while (n < 3000) begin
         if (busy || done) lat++;
         if (avm_read && !avm_address) begin
            c0++;
            if (c1 > 0) order_err = 1;
         end
         if (avm_read && avm_address) c1++;
         if (done) break;
         @(negedge clock);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL %s no_done: done=%b after %0d cycles, required 1", name, done, n);
      end
      checks++;
      if (lat !== e_lat) begin
         errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, e_lat);
      end
      checks++;
      if (c0 !== e_c0 || c1 !== e_c1 || order_err) begin
         errors++; $display("FAIL %s read_cycles: addr0=%0d addr1=%0d order_err=%0d required %0d/%0d/0",
                            name, c0, c1, order_err, e_c0, e_c1);
      end
      checks++;
      if ({id_ok, ts_ok, timeout} !== {e_id_ok, e_ts_ok, e_tmo}) begin
         errors++; $display("FAIL %s flags: id_ok/ts_ok/timeout=%b%b%b required %b%b%b",
                            name, id_ok, ts_ok, timeout, e_id_ok, e_ts_ok, e_tmo);
      end
      checks++;
      if (id_value !== m_id_value || ts_value !== m_ts_value) begin
         errors++; $display("FAIL %s values: id=%h ts=%h required id=%h ts=%h",
                            name, id_value, ts_value, m_id_value, m_ts_value);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (done !== 1'b0 || avm_read !== 1'b0 || id_value !== m_id_value ||
          ts_value !== m_ts_value || {id_ok, ts_ok, timeout} !== {e_id_ok, e_ts_ok, e_tmo}) begin
         errors++; $display("FAIL %s hold: done=%b read=%b id=%h ts=%h flags=%b%b%b required 0 0 %h %h %b%b%b",
                            name, done, avm_read, id_value, ts_value, id_ok, ts_ok, timeout,
                            m_id_value, m_ts_value, e_id_ok, e_ts_ok, e_tmo);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value} !== 71'd0) begin
         errors++; $display("FAIL reset_state: read=%b addr=%b busy=%b done=%b flags=%b%b%b id=%h ts=%h required all 0",
                            avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value);
      end
      reset_n = 1'b1;
      m_id_value = 32'd0;
      m_ts_value = 32'd0;
      repeat (2) @(negedge clock);
      checks++;
      if (avm_read !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL idle_no_start: read=%b done=%b required 0 0", avm_read, done);
      end
   endtask

   task automatic test_directed();
      run_seq(EXP_ID, EXP_TS, 0, 0, "zero_wait");
      run_seq(32'h11111112, EXP_TS, 0, 0, "bad_id");
      run_seq(EXP_ID, EXP_TS, 4, 4, "stall4");
      run_seq(EXP_ID, EXP_TS ^ 32'h1, 2, 0, "bad_ts");
   endtask

   task automatic test_timeout();
      run_seq(EXP_ID, EXP_TS, 0, 1000, "ts_stuck");
      run_seq(EXP_ID, EXP_TS, TMO, TMO, "stall_eq_limit");
      run_seq(EXP_ID, EXP_TS, 1000, 0, "id_stuck");
      run_seq(EXP_ID, EXP_TS, 0, 0, "after_stuck");
   endtask

   task automatic test_reset_mid_seq();
      int n;
      s_data_id = EXP_ID; s_data_ts = EXP_TS; s_stall_id = 0; s_stall_ts = 1000;
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      n = 0;
      while (!(avm_read && avm_address) && n < 50) begin
         @(negedge clock); n++;
      end
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value} !== 71'd0) begin
         errors++; $display("FAIL reset_mid_seq: read=%b addr=%b busy=%b done=%b flags=%b%b%b id=%h ts=%h required all 0",
                            avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value);
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      m_id_value = 32'd0;
      m_ts_value = 32'd0;
      repeat (3) @(negedge clock);
      checks++;
      if (done !== 1'b0 || avm_read !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: done=%b read=%b required 0 0", done, avm_read);
      end
      run_seq(EXP_ID, EXP_TS, 1, 2, "after_reset");
   endtask

   task automatic test_back_to_back();
      int dones;
      bit e_done;
      s_data_id = EXP_ID; s_data_ts = EXP_TS; s_stall_id = 0; s_stall_ts = 0;
      @(negedge clock) start = 1'b1;
      dones = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         e_done = ((i % 4) == 2);
         if (done) dones++;
         checks++;
         if (done !== e_done || busy !== ((i % 4) < 2)) begin
            errors++; $display("FAIL b2b_cycle%0d: done=%b busy=%b required %b %b",
                               i, done, busy, e_done, ((i % 4) < 2));
         end
      end
      start = 1'b0;
      checks++;
      if (dones !== 4 || id_ok !== 1'b1 || ts_ok !== 1'b1) begin
         errors++; $display("FAIL b2b_total: dones=%0d id_ok=%b ts_ok=%b required 4 1 1", dones, id_ok, ts_ok);
      end
      m_id_value = EXP_ID;
      m_ts_value = EXP_TS;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_random();
      logic [31:0] did, dts;
      for (int k = 0; k < 20; k++) begin
         did = ($urandom_range(1, 0) == 1) ? EXP_ID : EXP_ID ^ (32'd1 << $urandom_range(31, 0));
         dts = ($urandom_range(1, 0) == 1) ? EXP_TS : $urandom;
         run_seq(did, dts, int'($urandom_range(12, 0)), int'($urandom_range(12, 0)), "random");
      end
   endtask

   initial begin
`ifdef SYSID_CHECKER_TIMEOUT_EN
      tmo_en = 1'b1;
`else
      tmo_en = 1'b0;
`endif
      start = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdata = 32'd0;
      s_data_id = EXP_ID; s_data_ts = EXP_TS; s_stall_id = 0; s_stall_ts = 0;
      s_cnt = 0; s_key = 2'b00; s_prev_key = 2'b00;
      m_id_value = 32'd0; m_ts_value = 32'd0;
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid_seq();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
